// File: rtl/ifmap_release_ctrl.sv
// Gathers per-group PE completions into rounds, counts rounds up to a per-layer
// threshold and issues held ifmap-buffer release requests; reports layer end.
module ifmap_release_ctrl #(
  parameter int NUM_GROUPS = 4,
  parameter int CNT_W      = 5,
  parameter int BUF_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_rounds,
  input  logic [BUF_W-1:0]      cfg_bufs,
  input  logic [NUM_GROUPS-1:0] complete,
  input  logic                  free_ack,
  output logic                  free_ifmap_buffer,
  output logic                  layer_done,
  output logic                  busy,
  output logic [1:0]            err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_LAST
  } state_e;

  state_e                state_q;
  logic [NUM_GROUPS-1:0] flags_q;
  logic [NUM_GROUPS-1:0] flags_d;
  logic [CNT_W-1:0]      round_cnt_q;
  logic [CNT_W-1:0]      round_cnt_d;
  logic [CNT_W-1:0]      cfg_rounds_q;
  logic [BUF_W-1:0]      buf_cnt_q;
  logic [BUF_W-1:0]      buf_cnt_d;
  logic [BUF_W-1:0]      cfg_bufs_q;
  logic                  req_q;
  logic                  done_q;
  logic                  busy_q;
  logic [1:0]            err_q;

  logic round_close;
  logic thr_hit;
  logic ack;
  logic cfg_ok;
  logic dup;

  always_comb begin
    flags_d     = flags_q | complete;
    dup         = |(flags_q & complete);
    round_close = &flags_d;
    round_cnt_d = round_cnt_q + CNT_W'(1);
    buf_cnt_d   = buf_cnt_q + BUF_W'(1);
    thr_hit     = round_close && (round_cnt_d == cfg_rounds_q);
    ack         = req_q && free_ack;
    cfg_ok      = start && (cfg_rounds != '0) && (cfg_bufs != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flags_q      <= '0;
      round_cnt_q  <= '0;
      cfg_rounds_q <= '0;
      buf_cnt_q    <= '0;
      cfg_bufs_q   <= '0;
      req_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_ok) begin
            state_q      <= RUN;
            cfg_rounds_q <= cfg_rounds;
            cfg_bufs_q   <= cfg_bufs;
            flags_q      <= '0;
            round_cnt_q  <= '0;
            buf_cnt_q    <= '0;
            err_q        <= '0;
            busy_q       <= 1'b1;
          end
        end
        RUN: begin
          if (dup) err_q[1] <= 1'b1;
          flags_q <= round_close ? '0 : flags_d;
          if (thr_hit) begin
            // A new release merges with a pending one; only flag it when
            // the pending one is not being acknowledged this same cycle.
            round_cnt_q <= '0;
            buf_cnt_q   <= buf_cnt_d;
            req_q       <= 1'b1;
            if (req_q && !free_ack) err_q[0] <= 1'b1;
            if (buf_cnt_d == cfg_bufs_q) state_q <= WAIT_LAST;
          end else begin
            if (round_close) round_cnt_q <= round_cnt_d;
            if (ack) req_q <= 1'b0;
          end
        end
        WAIT_LAST: begin
          if (ack) begin
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign free_ifmap_buffer = req_q;
  assign layer_done        = done_q;
  assign busy              = busy_q;
  assign err               = err_q;

endmodule

// File: doc/ifmap_release_ctrl.md
# ifmap_release_ctrl

Parametrised successor to the per-layer PE completion counter. It gathers completion pulses from `NUM_GROUPS` PE groups into rounds, counts rounds up to a per-layer threshold loaded at layer start, then issues a held release request to the ifmap buffer with req/ack. After a configured number of buffer releases it reports layer completion. It sits between the PE array and the ifmap buffer in the accelerator control path.

## Interface
Parameters:
- `NUM_GROUPS`, 4, number of PE groups; a round needs one completion from every group.
- `CNT_W`, 5, width of the rounds-per-buffer threshold and counter.
- `BUF_W`, 8, width of the buffers-per-layer threshold and counter.

Ports:
- `clk`, in, 1, single clock; all logic on the rising edge.
- `rst_n`, in, 1, reset; asynchronous, active-low.
- `start`, in, 1, single-cycle pulse that begins a layer.
- `cfg_rounds`, in, CNT_W, rounds per buffer release (16 / 4 / 1 for layers 1 / 2 / 3); sampled on an accepted `start`.
- `cfg_bufs`, in, BUF_W, buffer releases per layer; sampled on an accepted `start`.
- `complete`, in, NUM_GROUPS, per-group single-cycle completion pulse.
- `free_ack`, in, 1, buffer accepts the release while `free_ifmap_buffer` is high.
- `free_ifmap_buffer`, out, 1, release request; held until acknowledged.
- `layer_done`, out, 1, one-cycle pulse when the last release of the layer is acknowledged.
- `busy`, out, 1, high in RUN and WAIT_LAST.
- `err`, out, 2, sticky errors. Bit 0 is overrun: a new release fell due while the previous one was still unacknowledged. Bit 1 is duplicate: a group completed again before its round closed.

## Operation
- States:
  - IDLE: `busy=0`.
  - RUN: counting rounds and issuing releases.
  - WAIT_LAST: final release is pending; completions are ignored.
- Start handling:
  - IDLE with `start`, `cfg_rounds!=0` and `cfg_bufs!=0`: go to RUN. Latch both config values. Clear group flags, `round_cnt`, `buf_cnt` and `err`.
  - `start` with a zero config value: ignored; stay in IDLE.
  - `start` outside IDLE: ignored.
- Round collection in RUN:
  - `flags_next = flags | complete`.
  - A `complete` bit whose flag is already set sets `err[1]`. The pulse is dropped, not carried into the next round.
  - A round closes when `flags_next` is all ones. Flags are then cleared to 0, including bits arriving in that same cycle.
- Round counting: on round close, if `round_cnt+1 == cfg_rounds`, the buffer threshold is hit. Otherwise `round_cnt` increments.
- On a buffer threshold hit:
  - `round_cnt` goes to 0, `buf_cnt` increments and `free_ifmap_buffer` goes to 1.
  - If `buf_cnt+1 == cfg_bufs`, go to WAIT_LAST; otherwise stay in RUN.
- Release handshake: `free_ifmap_buffer` clears in the cycle after `free_ifmap_buffer && free_ack`.
- Threshold hit while a request is pending:
  - With `free_ack` in the same cycle: the old request is consumed, the new one is asserted, and `free_ifmap_buffer` stays 1 without error.
  - Without `free_ack`: set `err[0]`; the requests merge and `free_ifmap_buffer` stays 1.
- `free_ack` with no request pending: ignored.
- WAIT_LAST: once `free_ifmap_buffer && free_ack`, clear the request, pulse `layer_done` for one cycle and return to IDLE.
- Counters never wrap: `round_cnt < cfg_rounds` and `buf_cnt <= cfg_bufs` at all times.

## Timing
- Reset values: IDLE; `free_ifmap_buffer=0`, `layer_done=0`, `busy=0`, `err=0`, flags 0, counters 0. Async reset mid-layer aborts immediately to this state.
- All outputs are registered.
- `busy` rises the cycle after an accepted `start`. `complete` is honoured in the cycle after `start` (the first RUN cycle), not in the `start` cycle itself.
- `free_ifmap_buffer` rises the cycle after the edge at which the final group of the threshold round completes.
- `layer_done` and the IDLE entry occur the cycle after the final ack. `start` is accepted again in the cycle `layer_done` is high.
- With `cfg_rounds=1` and all groups pulsing together every cycle, a release falls due every cycle. Sustained operation therefore needs `free_ack` held high, otherwise overrun is flagged.

## Test plan
- Layer-1 style: `cfg_rounds=16`, `cfg_bufs=2`; all 4 groups pulse together 32 times; `free_ack` 2 cycles after each request.
  - Required: exactly 2 requests; each rises 1 cycle after the 16th/32nd round; `layer_done` pulses once; `err=0`.
- Staggered groups: groups 0..3 pulse on consecutive cycles, `cfg_rounds=1`.
  - Required: a round closes only on the group-3 pulse; the request appears 1 cycle later.
- Duplicate: group 0 pulses twice before group 1 reports.
  - Required: `err[1]=1`; the round still closes after groups 1..3 report; the count advances by 1 only.
- Overrun: `cfg_rounds=1`, `cfg_bufs=4`, all groups pulse every cycle, `free_ack=0` for 3 cycles then 1.
  - Required: `err[0]=1`; `free_ifmap_buffer` stays 1 throughout.
- Same-cycle ack and new threshold hit.
  - Required: `free_ifmap_buffer` stays 1; `err[0]=0`; `buf_cnt` advances.
- Control corners:
  - `start` with `cfg_bufs=0`: remains IDLE.
  - `start` during RUN: ignored.
  - `rst_n` low mid-layer: all outputs 0 at once; the next `start` runs a fresh layer.
